// File: rtl/load_store_unit_if.sv
// APB-style bus between the load/store unit (master) and data RAM / peripherals (slave).
interface load_store_unit_if;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PADDR, PWDATA, PSTRB, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PSTRB, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns a datapath memory request into one APB transfer, stalling the core
// until completion and reporting misaligned, illegal, slave-error or timed-out accesses.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    load_store_unit_if.master bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic               we_reg;
    logic [2:0]         funct3_reg;
    logic [1:0]         lane_reg;
    logic [31:0]        paddr_reg, pwdata_reg, rdata_reg;
    logic [3:0]         pstrb_reg;
    logic               err_reg;

    logic               legal, misaligned, timeout;
    logic [31:0]        pwdata_fmt, load_fmt;
    logic [3:0]         pstrb_fmt;
    logic [7:0]         rd_byte [4];
    logic [7:0]         byte_sel;
    logic [15:0]        half_sel;

    always_comb begin
        legal      = req_we ? (funct3 inside {3'b000, 3'b001, 3'b010})
                            : (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    end

    // Store data is replicated across lanes so the slave can pick it up by strobe alone.
    always_comb begin
        case (funct3[1:0])
            2'b00: begin
                pwdata_fmt = {4{wdata[7:0]}};
                pstrb_fmt  = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                pwdata_fmt = {2{wdata[15:0]}};
                pstrb_fmt  = 4'b0011 << addr[1:0];
            end
            default: begin
                pwdata_fmt = wdata;
                pstrb_fmt  = 4'b1111;
            end
        endcase
        if (!req_we) begin
            pstrb_fmt = 4'b0000;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rd_byte
            assign rd_byte[gi] = bus.PRDATA[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        byte_sel = rd_byte[lane_reg];
        half_sel = lane_reg[1] ? bus.PRDATA[31:16] : bus.PRDATA[15:0];
        case (funct3_reg)
            3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_fmt = {24'h000000, byte_sel};
            3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_fmt = {16'h0000, half_sel};
            default: load_fmt = bus.PRDATA;
        endcase
        if (we_reg) begin
            load_fmt = 32'h0000_0000;
        end
    end

    assign timeout = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        stall       = 1'b0;
        done        = 1'b0;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        case (state_reg)
            IDLE: begin
                stall = req_valid;
                if (req_valid) begin
                    state_next = (legal && !misaligned) ? SETUP : RESP;
                end
            end
            SETUP: begin
                stall      = 1'b1;
                bus.PSEL   = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                stall       = 1'b1;
                bus.PSEL    = 1'b1;
                bus.PENABLE = 1'b1;
                if (bus.PREADY || timeout) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg    <= '0;
            we_reg     <= 1'b0;
            funct3_reg <= 3'b000;
            lane_reg   <= 2'b00;
            paddr_reg  <= 32'h0;
            pwdata_reg <= 32'h0;
            pstrb_reg  <= 4'h0;
            rdata_reg  <= 32'h0;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (req_valid) begin
                        we_reg     <= req_we;
                        funct3_reg <= funct3;
                        lane_reg   <= addr[1:0];
                        paddr_reg  <= {addr[31:2], 2'b00};
                        pwdata_reg <= pwdata_fmt;
                        pstrb_reg  <= pstrb_fmt;
                        if (!(legal && !misaligned)) begin
                            rdata_reg <= 32'h0;
                            err_reg   <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (bus.PREADY) begin
                        rdata_reg <= load_fmt;
                        err_reg   <= bus.PSLVERR;
                    end else if (timeout) begin
                        rdata_reg <= 32'h0;
                        err_reg   <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.PADDR  = paddr_reg;
    assign bus.PWDATA = pwdata_reg;
    assign bus.PSTRB  = pstrb_reg;
    assign bus.PWRITE = we_reg;
    assign rdata      = rdata_reg;
    assign err        = err_reg;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver queues expected responses, a monitor
// checks bus fields during each transfer and the response at every done pulse.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, rdata;
    logic        stall, done, err;

    load_store_unit_if bus();

    load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .funct3(funct3), .addr(addr), .wdata(wdata), .rdata(rdata),
        .stall(stall), .done(done), .err(err), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        has_bus;
        logic        aborted;
        logic        chk_wdata;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
        logic        pwrite;
        logic [31:0] rdata;
        logic        err;
        int          stall_cycles;
        int          acc_cycles;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic flag(input string name);
        total_cnt++;
        $display("FAIL %s", name);
    endtask

    // Slave: raise PREADY after slv_wait extra ACCESS cycles; negative means never.
    int slv_wait = 0;
    int slv_acc  = 0;
    always @(negedge clk) begin
        if (bus.PSEL && bus.PENABLE) begin
            bus.PREADY = (slv_wait >= 0) && (slv_acc == slv_wait);
            slv_acc++;
        end else begin
            bus.PREADY = 1'b0;
            slv_acc    = 0;
        end
    end

    // Monitor
    int   mon_stall = 0;
    int   mon_acc   = 0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            mon_stall = 0;
            mon_acc   = 0;
        end else begin
            if (stall) mon_stall++;
            if (bus.PSEL) begin
                if (exp_q.size() == 0 || !exp_q[0].has_bus) begin
                    flag("unexpected_bus_activity");
                end else begin
                    mon_e = exp_q[0];
                    check($sformatf("txn%0d_paddr", mon_e.id), bus.PADDR, mon_e.paddr);
                    check($sformatf("txn%0d_pstrb", mon_e.id), {28'h0, bus.PSTRB}, {28'h0, mon_e.pstrb});
                    check($sformatf("txn%0d_pwrite", mon_e.id), {31'h0, bus.PWRITE}, {31'h0, mon_e.pwrite});
                    if (mon_e.chk_wdata)
                        check($sformatf("txn%0d_pwdata", mon_e.id), bus.PWDATA, mon_e.pwdata);
                end
                if (bus.PENABLE) mon_acc++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    flag("unexpected_done");
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.aborted) begin
                        flag($sformatf("txn%0d_done_after_reset", mon_e.id));
                    end else begin
                        check($sformatf("txn%0d_rdata", mon_e.id), rdata, mon_e.rdata);
                        check($sformatf("txn%0d_err", mon_e.id), {31'h0, err}, {31'h0, mon_e.err});
                        check($sformatf("txn%0d_stall_cycles", mon_e.id), mon_stall, mon_e.stall_cycles);
                        check($sformatf("txn%0d_access_cycles", mon_e.id), mon_acc, mon_e.acc_cycles);
                        check($sformatf("txn%0d_stall_at_done", mon_e.id), {31'h0, stall}, 32'h0);
                        $display("txn%0d done rdata=0x%08h err=%0b stall=%0d access=%0d",
                                 mon_e.id, rdata, err, mon_stall, mon_acc);
                    end
                end
                mon_stall = 0;
                mon_acc   = 0;
            end
        end
    end

    // Called right after a rising edge; holds req_valid through the RESP edge.
    task automatic run_txn(input int id, input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] prd,
                           input int wt, input logic slverr, input logic has_bus,
                           input logic [31:0] e_paddr, input logic [31:0] e_pwdata,
                           input logic [3:0] e_pstrb, input logic [31:0] e_rdata,
                           input logic e_err, input int e_acc);
        exp_t e;
        bit   got;
        e.id = id; e.has_bus = has_bus; e.aborted = 1'b0; e.chk_wdata = we;
        e.paddr = e_paddr; e.pwdata = e_pwdata; e.pstrb = e_pstrb; e.pwrite = we;
        e.rdata = e_rdata; e.err = e_err; e.acc_cycles = e_acc;
        e.stall_cycles = has_bus ? (2 + e_acc) : 1;
        exp_q.push_back(e);
        bus.PRDATA  = prd;
        bus.PSLVERR = slverr;
        slv_wait    = wt;
        req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            flag($sformatf("txn%0d_no_done_within_40_cycles", id));
            void'(exp_q.pop_front());
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic reset_abort(input int id);
        exp_t e;
        e.id = id; e.has_bus = 1'b1; e.aborted = 1'b1; e.chk_wdata = 1'b0;
        e.paddr = 32'h0000_1000; e.pwdata = 32'h0; e.pstrb = 4'h0; e.pwrite = 1'b0;
        e.rdata = 32'h0; e.err = 1'b0; e.stall_cycles = 0; e.acc_cycles = 0;
        exp_q.push_back(e);
        slv_wait = -1;
        req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h0000_1000; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_in_access_penable", {31'h0, bus.PENABLE}, 32'h1);
        reset = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_psel", {31'h0, bus.PSEL}, 32'h0);
        check("abort_penable", {31'h0, bus.PENABLE}, 32'h0);
        check("abort_stall", {31'h0, stall}, 32'h0);
        check("abort_done", {31'h0, done}, 32'h0);
        @(negedge clk);
        check("abort_done_later", {31'h0, done}, 32'h0);
        void'(exp_q.pop_front());
        slv_wait = 0;
        @(posedge clk); #1;
        $display("txn%0d aborted by reset", id);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0;
        bus.PRDATA = 32'h0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rdata", rdata, 32'h0);
        check("reset_stall", {31'h0, stall}, 32'h0);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_err", {31'h0, err}, 32'h0);
        check("reset_psel", {31'h0, bus.PSEL}, 32'h0);
        check("reset_penable", {31'h0, bus.PENABLE}, 32'h0);
        check("reset_paddr", bus.PADDR, 32'h0);
        check("reset_pwdata", bus.PWDATA, 32'h0);
        check("reset_pstrb", {28'h0, bus.PSTRB}, 32'h0);
        check("reset_pwrite", {31'h0, bus.PWRITE}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        //      id we f3      addr          wdata         prdata        wt slv bus paddr         pwdata        pstrb    rdata         err acc
        run_txn(1, 0, 3'b010, 32'h0000_1000, 32'h0,        32'hDEADBEEF, 0, 0, 1, 32'h0000_1000, 32'h0,        4'b0000, 32'hDEADBEEF, 0, 1);
        @(negedge clk);
        check("hold_rdata_after_lw", rdata, 32'hDEADBEEF);
        check("hold_err_after_lw", {31'h0, err}, 32'h0);
        @(posedge clk); #1;
        run_txn(2, 0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF1234, 0, 0, 1, 32'h0000_1000, 32'h0,        4'b0000, 32'hFFFFFF80, 0, 1);
        run_txn(3, 0, 3'b100, 32'h0000_1003, 32'h0,        32'h80FF1234, 0, 0, 1, 32'h0000_1000, 32'h0,        4'b0000, 32'h00000080, 0, 1);
        run_txn(4, 0, 3'b101, 32'h0000_1002, 32'h0,        32'h80FF1234, 0, 0, 1, 32'h0000_1000, 32'h0,        4'b0000, 32'h000080FF, 0, 1);
        run_txn(5, 0, 3'b001, 32'h0000_1002, 32'h0,        32'h80FF1234, 0, 0, 1, 32'h0000_1000, 32'h0,        4'b0000, 32'hFFFF80FF, 0, 1);
        run_txn(6, 0, 3'b000, 32'h0000_1001, 32'h0,        32'h80FF1234, 0, 0, 1, 32'h0000_1000, 32'h0,        4'b0000, 32'h00000012, 0, 1);
        run_txn(7, 1, 3'b000, 32'h0000_2001, 32'h000000A5, 32'h12345678, 0, 0, 1, 32'h0000_2000, 32'hA5A5A5A5, 4'b0010, 32'h00000000, 0, 1);
        run_txn(8, 1, 3'b001, 32'h0000_2002, 32'h00001234, 32'h12345678, 0, 0, 1, 32'h0000_2000, 32'h12341234, 4'b1100, 32'h00000000, 0, 1);
        run_txn(9, 1, 3'b010, 32'h0000_2004, 32'hCAFEF00D, 32'h12345678, 2, 0, 1, 32'h0000_2004, 32'hCAFEF00D, 4'b1111, 32'h00000000, 0, 3);
        run_txn(10, 0, 3'b010, 32'h0000_1002, 32'h0,       32'h55555555, 0, 0, 0, 32'h0,         32'h0,        4'b0000, 32'h00000000, 1, 0);
        run_txn(11, 0, 3'b011, 32'h0000_1000, 32'h0,       32'h55555555, 0, 0, 0, 32'h0,         32'h0,        4'b0000, 32'h00000000, 1, 0);
        run_txn(12, 1, 3'b001, 32'h0000_2001, 32'h1234,    32'h55555555, 0, 0, 0, 32'h0,         32'h0,        4'b0000, 32'h00000000, 1, 0);
        run_txn(13, 1, 3'b100, 32'h0000_2000, 32'h1234,    32'h55555555, 0, 0, 0, 32'h0,         32'h0,        4'b0000, 32'h00000000, 1, 0);
        run_txn(14, 0, 3'b010, 32'h0000_3000, 32'h0,       32'h77777777, -1, 0, 1, 32'h0000_3000, 32'h0,       4'b0000, 32'h00000000, 1, 16);
        @(negedge clk);
        check("hold_err_after_timeout", {31'h0, err}, 32'h1);
        check("hold_rdata_after_timeout", rdata, 32'h0);
        @(posedge clk); #1;
        run_txn(15, 0, 3'b010, 32'h0000_3004, 32'h0,       32'h11223344, 0, 1, 1, 32'h0000_3004, 32'h0,        4'b0000, 32'h11223344, 1, 1);
        reset_abort(16);
        run_txn(17, 0, 3'b010, 32'h0000_1000, 32'h0,       32'h0BADF00D, 0, 0, 1, 32'h0000_1000, 32'h0,        4'b0000, 32'h0BADF00D, 0, 1);

        repeat (3) @(posedge clk);
        check("scoreboard_empty", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
